// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: FSM state encoding,
// program entry points and the absolute-branch jump table.
package pc_seq_pkg;

    localparam int PKG_D        = 12;
    localparam int PKG_NUM_PROG = 3;
    localparam int PKG_LUT_AW   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pc_seq_state_t;

    // Entry point per program; element 0 is the rightmost in the concatenation.
    localparam logic [PKG_NUM_PROG-1:0][PKG_D-1:0] PROG_ENTRY = {
        12'h200, 12'h100, 12'h000
    };

    // Absolute branch targets indexed by branch_field (element 0 rightmost).
    localparam logic [(2**PKG_LUT_AW)-1:0][PKG_D-1:0] JUMP_LUT = {
        12'hFFF, 12'hA00, 12'h800, 12'h700,
        12'h680, 12'h600, 12'h580, 12'h500,
        12'h480, 12'h400, 12'h3C0, 12'h300,
        12'h0C0, 12'h080, 12'h040, 12'h000
    };

endpackage

// File: rtl/jump_lut.sv
// Combinational ROM mapping a jump-table index to an absolute PC target.
module jump_lut
    import pc_seq_pkg::*;
#(
    parameter int D      = 12,
    parameter int LUT_AW = 4
) (
    input  logic [LUT_AW-1:0] idx,
    output logic [D-1:0]      target
);

    // Pure table lookup, resized to the program-counter width.
    always_comb begin
        target = D'(JUMP_LUT[idx]);
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, the req/done handshake, branch
// resolution (LUT-absolute and signed relative), halt detection and a
// saturating run-cycle counter. Optional watchdog built when the macro
// PC_SEQ_WATCHDOG_EN is defined; otherwise timeout stays 0.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int D        = 12,
    parameter int NUM_PROG = 3,
    parameter int LUT_AW   = 4,
    parameter int CW       = 16,
    parameter int MAX_CYC  = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    input  logic [$clog2(NUM_PROG)-1:0] prog_sel,
    input  logic                        halt,
    input  logic                        branch_en,
    input  logic                        branch_abs,
    input  logic [LUT_AW-1:0]           branch_field,
    output logic [D-1:0]                prog_ctr,
    output logic                        run,
    output logic                        done,
    output logic [CW-1:0]               cycle_cnt,
    output logic                        timeout
);

    localparam int SEL_W = $clog2(NUM_PROG);
    localparam logic [D-1:0]     PC_ONE   = {{(D-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

    // Elaboration-time sanity check on the watchdog limit.
    if (MAX_CYC < 32'sd1) begin : g_max_cyc_check
        $error("pc_sequencer: MAX_CYC must be at least 1");
    end

    pc_seq_state_t state_r;
    pc_seq_state_t state_nxt_s;

    logic [D-1:0]  prog_ctr_r;
    logic [D-1:0]  prog_ctr_nxt_s;
    logic [CW-1:0] cycle_cnt_r;
    logic [CW-1:0] cycle_cnt_nxt_s;
    logic          timeout_r;
    logic          timeout_nxt_s;
    logic          run_r;
    logic          done_r;

    logic [D-1:0]  entry_s;
    logic [D-1:0]  lut_target_s;
    logic [D-1:0]  rel_target_s;
    logic [CW-1:0] cnt_sat_inc_s;
    logic          wd_hit_s;

    jump_lut #(
        .D      (D),
        .LUT_AW (LUT_AW)
    ) u_jump_lut (
        .idx    (branch_field),
        .target (lut_target_s)
    );

    // Entry-point select; out-of-range selections fall back to entry 0.
    always_comb begin
        if (int'(prog_sel) < NUM_PROG) begin
            entry_s = D'(PROG_ENTRY[prog_sel]);
        end else begin
            entry_s = D'(PROG_ENTRY[SEL_ZERO]);
        end
    end

    // Relative target: sign-extended offset added modulo 2^D.
    always_comb begin
        rel_target_s = prog_ctr_r
                     + {{(D-LUT_AW){branch_field[LUT_AW-1]}}, branch_field};
    end

    // Cycle counter increment that sticks at all-ones.
    always_comb begin
        if (cycle_cnt_r == {CW{1'b1}}) begin
            cnt_sat_inc_s = cycle_cnt_r;
        end else begin
            cnt_sat_inc_s = cycle_cnt_r + CNT_ONE;
        end
    end

`ifdef PC_SEQ_WATCHDOG_EN
    localparam logic [CW-1:0] WD_LIMIT = CW'(MAX_CYC - 1);
    assign wd_hit_s = (cycle_cnt_r == WD_LIMIT);
`else
    assign wd_hit_s = 1'b0;
`endif

    // Next-state and next-datapath logic; halt outranks the watchdog,
    // which outranks branches and the sequential increment.
    always_comb begin
        state_nxt_s     = state_r;
        prog_ctr_nxt_s  = prog_ctr_r;
        cycle_cnt_nxt_s = cycle_cnt_r;
        timeout_nxt_s   = timeout_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_nxt_s     = RUN;
                    prog_ctr_nxt_s  = entry_s;
                    cycle_cnt_nxt_s = {CW{1'b0}};
                    timeout_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                cycle_cnt_nxt_s = cnt_sat_inc_s;
                if (halt) begin
                    state_nxt_s = DONE;
                end else if (wd_hit_s) begin
                    state_nxt_s   = DONE;
                    timeout_nxt_s = 1'b1;
                end else if (branch_en && branch_abs) begin
                    prog_ctr_nxt_s = lut_target_s;
                end else if (branch_en) begin
                    prog_ctr_nxt_s = rel_target_s;
                end else begin
                    prog_ctr_nxt_s = prog_ctr_r + PC_ONE;
                end
            end
            DONE: begin
                if (!req) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                prog_ctr_nxt_s  = {D{1'b0}};
                cycle_cnt_nxt_s = {CW{1'b0}};
                timeout_nxt_s   = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers; run/done decoded from the next state
    // so they are registered and aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            prog_ctr_r  <= {D{1'b0}};
            cycle_cnt_r <= {CW{1'b0}};
            timeout_r   <= 1'b0;
            run_r       <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            prog_ctr_r  <= prog_ctr_nxt_s;
            cycle_cnt_r <= cycle_cnt_nxt_s;
            timeout_r   <= timeout_nxt_s;
            run_r       <= (state_nxt_s == RUN);
            done_r      <= (state_nxt_s == DONE);
        end
    end

    assign prog_ctr  = prog_ctr_r;
    assign cycle_cnt = cycle_cnt_r;
    assign timeout   = timeout_r;
    assign run       = run_r;
    assign done      = done_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer plus hand-written sequences
// for the self-loop / watchdog corner cases.
module tb_pc_sequencer;

    localparam int WD_LIM = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  prog_sel;
    logic        halt;
    logic        branch_en;
    logic        branch_abs;
    logic [3:0]  branch_field;
    logic [11:0] prog_ctr;
    logic        run;
    logic        done;
    logic [15:0] cycle_cnt;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        rq;
        logic [1:0]  sel;
        logic        h;
        logic        be;
        logic        ba;
        logic [3:0]  bf;
        logic [11:0] epc;
        logic        erun;
        logic        edone;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer #(
        .D        (12),
        .NUM_PROG (3),
        .LUT_AW   (4),
        .CW       (16),
        .MAX_CYC  (WD_LIM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .prog_sel     (prog_sel),
        .halt         (halt),
        .branch_en    (branch_en),
        .branch_abs   (branch_abs),
        .branch_field (branch_field),
        .prog_ctr     (prog_ctr),
        .run          (run),
        .done         (done),
        .cycle_cnt    (cycle_cnt),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic rq, input logic [1:0] s,
                       input logic h, input logic be, input logic ba,
                       input logic [3:0] bf, input logic [11:0] pc,
                       input logic ru, input logic dn, input logic [15:0] cnt);
        vec_t v;
        v.rst = r; v.rq = rq; v.sel = s; v.h = h; v.be = be; v.ba = ba;
        v.bf = bf; v.epc = pc; v.erun = ru; v.edone = dn; v.ecnt = cnt;
        vecs.push_back(v);
    endtask

    // Apply inputs, clock once, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic rq, input logic [1:0] s,
                        input logic h, input logic be, input logic ba,
                        input logic [3:0] bf);
        reset = r; req = rq; prog_sel = s; halt = h;
        branch_en = be; branch_abs = ba; branch_field = bf;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] pc,
                         input logic ru, input logic dn,
                         input logic [15:0] cnt, input logic to);
        checks++;
        if ({prog_ctr, run, done, cycle_cnt, timeout} !== {pc, ru, dn, cnt, to}) begin
            errors++;
            $display("FAIL %s: got pc=%h run=%b done=%b cnt=%0d timeout=%b, want pc=%h run=%b done=%b cnt=%0d timeout=%b",
                     name, prog_ctr, run, done, cycle_cnt, timeout, pc, ru, dn, cnt, to);
        end
    endtask

    initial begin
        logic        exp_run;
        logic        exp_done;
        logic        exp_to;
        logic [15:0] exp_cnt;

        // rst rq sel h be ba bf       pc     run done cnt
        add(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 16'd0); // 0 reset
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h100, 1'b1, 1'b0, 16'd0); // 1 start prog 1
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h101, 1'b1, 1'b0, 16'd1);
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h102, 1'b1, 1'b0, 16'd2);
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h103, 1'b1, 1'b0, 16'd3);
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h104, 1'b1, 1'b0, 16'd4);
        add(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 4'h0, 12'h104, 1'b0, 1'b1, 16'd5); // 6 halt
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h104, 1'b0, 1'b1, 16'd5); // req held
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h104, 1'b0, 1'b1, 16'd5);
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h104, 1'b0, 1'b1, 16'd5);
        add(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h104, 1'b0, 1'b0, 16'd5); // 10 release
        add(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 16'd0); // 11 sel out of range
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h001, 1'b1, 1'b0, 16'd1);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h002, 1'b1, 1'b0, 16'd2);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h003, 1'b1, 1'b0, 16'd3);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'hE, 12'h001, 1'b1, 1'b0, 16'd4); // 15 rel -2
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h002, 1'b1, 1'b0, 16'd5);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h003, 1'b1, 1'b0, 16'd6);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'h7, 12'h00A, 1'b1, 1'b0, 16'd7); // 18 rel +7
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'h5, 12'h3C0, 1'b1, 1'b0, 16'd8); // 19 abs LUT[5]
        add(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 4'h5, 12'h3C0, 1'b0, 1'b1, 16'd9); // 20 halt beats abs
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h3C0, 1'b0, 1'b0, 16'd9); // 21 back to idle
        add(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0, 12'h200, 1'b1, 1'b0, 16'd0); // 22 restart prog 2
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'h0, 12'h200, 1'b1, 1'b0, 16'd1); // 23 self-loop
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'hF, 12'hFFF, 1'b1, 1'b0, 16'd2); // 24 abs LUT[15]
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'h2, 12'h001, 1'b1, 1'b0, 16'd3); // 25 rel wrap
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'hF, 12'hFFF, 1'b1, 1'b0, 16'd4);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 16'd5); // 27 +1 wrap
        add(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 16'd0); // 28 reset mid-run
        add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'h0, 12'h100, 1'b1, 1'b0, 16'd0);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h101, 1'b1, 1'b0, 16'd1);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h102, 1'b1, 1'b0, 16'd2);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h103, 1'b1, 1'b0, 16'd3);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h104, 1'b1, 1'b0, 16'd4);
        add(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h105, 1'b1, 1'b0, 16'd5);
        add(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b0, 16'd0); // 35 reset at 0x105
        add(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 1'b1, 1'b0, 16'd0); // 36 start prog 0

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].rq, vecs[i].sel, vecs[i].h,
                 vecs[i].be, vecs[i].ba, vecs[i].bf);
            check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].erun,
                  vecs[i].edone, vecs[i].ecnt, 1'b0);
        end

        // Self-loop program at 0x000 with req held high.
        for (int i = 1; i <= 40; i++) begin
            step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'h0);
            exp_run  = 1'b1;
            exp_done = 1'b0;
            exp_to   = 1'b0;
            exp_cnt  = 16'(i);
`ifdef PC_SEQ_WATCHDOG_EN
            if (i >= WD_LIM) begin
                exp_run  = 1'b0;
                exp_done = 1'b1;
                exp_to   = 1'b1;
                exp_cnt  = 16'(WD_LIM);
            end
`endif
            check($sformatf("selfloop%0d", i), 12'h000, exp_run, exp_done, exp_cnt, exp_to);
        end

        // Halt ends the loop (or is ignored if the watchdog already fired).
`ifdef PC_SEQ_WATCHDOG_EN
        exp_cnt = 16'(WD_LIM);
        exp_to  = 1'b1;
`else
        exp_cnt = 16'd41;
        exp_to  = 1'b0;
`endif
        step(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("loop_halt", 12'h000, 1'b0, 1'b1, exp_cnt, exp_to);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        check("loop_release", 12'h000, 1'b0, 1'b0, exp_cnt, exp_to);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 4'h0);
        check("restart_clears", 12'h200, 1'b1, 1'b0, 16'd0, 1'b0);

`ifdef PC_SEQ_WATCHDOG_EN
        // Halt exactly on the limit cycle wins over the watchdog.
        for (int i = 1; i < WD_LIM; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        end
        check("wd_pre_limit", 12'h20F, 1'b1, 1'b0, 16'(WD_LIM - 1), 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("wd_halt_wins", 12'h20F, 1'b0, 1'b1, 16'(WD_LIM), 1'b0);
`else
        // Plain program continues past the watchdog limit untouched.
        for (int i = 1; i <= WD_LIM + 4; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'h0);
        end
        check("no_wd_run", 12'h214, 1'b1, 1'b0, 16'(WD_LIM + 4), 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("no_wd_halt", 12'h214, 1'b0, 1'b1, 16'(WD_LIM + 5), 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised successor to the processor's fixed program-counter path. It owns the program counter, the run/done request handshake and branch-target resolution for the core. It adds selectable program entry points, signed relative branches alongside LUT-absolute branches, halt detection, a saturating run-cycle counter and an optional watchdog. It sits between the instruction decoder/ALU (halt, branch inputs) and the instruction ROM (`prog_ctr`), and gates register-file and memory writes via `run`.

## Interface
- `D`, 12, program-counter width in bits.
- `NUM_PROG`, 3, number of selectable program entry points.
- `LUT_AW`, 4, jump-LUT index width; the LUT has 2^LUT_AW entries.
- `CW`, 16, cycle-counter width.
- `MAX_CYC`, 4096, watchdog limit in RUN cycles; used only when the watchdog is compiled in.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  start request, four-phase handshake with `done`.
- `prog_sel`  in  $clog2(NUM_PROG)  entry-point select, sampled with `req` in IDLE.
- `halt`  in  1  decoded halt instruction at the current `prog_ctr`.
- `branch_en`  in  1  branch taken (from ALU).
- `branch_abs`  in  1  1: absolute target from the LUT; 0: relative offset.
- `branch_field`  in  LUT_AW  LUT index, or signed relative offset.
- `prog_ctr`  out  D  current instruction address.
- `run`  out  1  core active; qualifies RegWrite/MemWrite.
- `done`  out  1  program finished.
- `cycle_cnt`  out  CW  RUN cycles of the last or current program.
- `timeout`  out  1  the last program was ended by the watchdog.

## Operation
FSM states: IDLE, RUN, DONE. Reset forces IDLE with `prog_ctr`=0, `run`=0, `done`=0, `cycle_cnt`=0 and `timeout`=0. This holds from any state, including mid-RUN.

IDLE:
- With `req`=1: `prog_ctr` <= PROG_ENTRY[`prog_sel`], `cycle_cnt` <= 0, `timeout` <= 0, go to RUN.
- A `prog_sel` value >= NUM_PROG selects entry 0.
- Otherwise all outputs hold.

RUN (`run`=1), priority order:
1. `halt`=1: go to DONE; `prog_ctr` holds at the halt address.
2. `branch_en`=1 with `branch_abs`=1: `prog_ctr` <= JUMP_LUT[`branch_field`].
3. `branch_en`=1 with `branch_abs`=0: `prog_ctr` <= `prog_ctr` + sign-extended `branch_field`, computed modulo 2^D. With LUT_AW=4 the range is -8..+7. An offset of 0 is a self-loop.
4. Otherwise `prog_ctr` <= `prog_ctr` + 1, wrapping from 2^D-1 to 0.

Additional RUN rules:
- `cycle_cnt` increments every RUN cycle, including the halt cycle, and saturates at 2^CW-1.
- `req` is ignored while in RUN.

DONE (`done`=1, `run`=0):
- `prog_ctr` and `cycle_cnt` hold.
- When `req`=0 is seen, go to IDLE.
- `req` must drop before a new start is accepted, so a held `req` never restarts a program.

## Timing
- Start latency: `req` sampled high in IDLE at edge N gives `run`=1 and `prog_ctr`=entry from edge N to N+1.
- `prog_ctr` changes only on clock edges. Branch inputs are combinational from the current instruction and take effect at the next edge.
- Halt: `halt`=1 in cycle k gives `done`=1 and `run`=0 from edge k+1.
- Handshake release: `req` low sampled in DONE gives `done`=0 from the next edge. The earliest restart is one cycle later.
- No output depends combinationally on any input; every output is a register.

## Configuration
- Macro `PC_SEQ_WATCHDOG_EN` defined:
  - In RUN, when `cycle_cnt`==MAX_CYC-1 and `halt`=0, go to DONE and set `timeout`=1.
  - `timeout` clears on the next accepted start.
  - If `halt` arrives on the limit cycle, halt wins and `timeout` stays 0.
- Macro undefined: no watchdog logic is built; `timeout` is tied to 0 and `MAX_CYC` is ignored.

## Structure
- Shared package `pc_seq_pkg` holds:
  - the state enum `pc_seq_state_t` (IDLE, RUN, DONE);
  - PROG_ENTRY, an array of NUM_PROG D-bit constants;
  - JUMP_LUT, an array of 2^LUT_AW D-bit constants.
- One sub-module, `jump_lut`: a combinational ROM from index to D-bit target. It replaces the current PC_Controller lookup.
- Everything else stays in `pc_sequencer`.

## Test plan
Examples use D=12 and PROG_ENTRY = {0x000, 0x100, 0x200}.
- Reset mid-RUN at `prog_ctr`=0x105 -> next edge: state IDLE, `prog_ctr`=0, `done`=0, `run`=0, `cycle_cnt`=0.
- `req`=1 with `prog_sel`=1, no branches, `halt` at 0x104 -> `prog_ctr` steps 0x100..0x104, `done`=1 one edge later, `cycle_cnt`=5. `req` held for 3 more cycles -> `done` stays 1 and no restart.
- Relative branches at `prog_ctr`=0x003: `branch_field`=4'b1110 -> 0x001; `branch_field`=4'b0111 -> 0x00A. At 0xFFF with offset +2 -> 0x001 (wrap).
- Absolute branch with JUMP_LUT[5]=0x3C0: `branch_abs`=1, `branch_field`=5 -> `prog_ctr`=0x3C0. The same cycle with `halt`=1 -> `prog_ctr` holds and `done` rises.
- `prog_sel`=3 (out of range) -> starts at 0x000. After DONE, drop `req` and re-raise with `prog_sel`=2 -> starts at 0x200 with `cycle_cnt` cleared.
- With `PC_SEQ_WATCHDOG_EN` and MAX_CYC=8, a self-loop program (offset 0) -> `done`=1 and `timeout`=1 after 8 RUN cycles, `cycle_cnt`=8. Without the macro, it runs indefinitely with `timeout`=0.
